// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide controller for the execute stage: 32-step shift-add multiplier
// and restoring divider, with a pipeline stall request and a one-cycle result strobe.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StartE,
    input  logic [1:0]       MulDivOpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             FlushE,
    output logic             StallMD,
    output logic             DoneE,
    output logic [WIDTH-1:0] MulDivResultE,
    output logic             BusyMD
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_count;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_operand;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_result;

    logic               w_divZero;
    logic               w_start;
    logic               w_step;
    logic               w_last;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mulNext;
    logic [WIDTH:0]     w_shifted;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_remNext;
    logic [WIDTH-1:0]   w_quoNext;
    logic [WIDTH-1:0]   w_finalResult;

    assign w_divZero = MulDivOpE[1] && (SrcBE == '0);
    assign w_start   = (r_state == S_IDLE) && StartE && !FlushE;
    assign w_step    = (r_state == S_RUN) && !FlushE;
    assign w_last    = w_step && (r_count == LAST);

    // Multiply step: conditional add into the upper half, carry kept, then shift right.
    assign w_sum     = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_operand} : '0);
    assign w_mulNext = {w_sum, r_prod[WIDTH-1:1]};

    // Divide step: the low half of r_prod shifts dividend bits out and quotient bits in.
    // A restore only happens when the trial value's top bit is 0, so r_rem stays WIDTH bits.
    assign w_shifted = {r_rem, r_prod[WIDTH-1]};
    assign w_diff    = w_shifted - {1'b0, r_operand};
    assign w_remNext = w_diff[WIDTH] ? w_shifted[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_quoNext = {r_prod[WIDTH-2:0], ~w_diff[WIDTH]};

    always_comb begin
        w_finalResult = '0;
        case (r_op)
            2'b00:   w_finalResult = w_mulNext[WIDTH-1:0];
            2'b01:   w_finalResult = w_mulNext[2*WIDTH-1:WIDTH];
            2'b10:   w_finalResult = w_quoNext;
            default: w_finalResult = w_remNext;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Divide-by-zero still raises the stall for its first cycle so every M-op looks alike.
    always_comb begin
        w_next  = r_state;
        StallMD = 1'b0;
        DoneE   = 1'b0;
        BusyMD  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    StallMD = 1'b1;
                    w_next  = w_divZero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                StallMD = 1'b1;
                BusyMD  = 1'b1;
                if (FlushE) begin
                    w_next = S_IDLE;
                end else if (r_count == LAST) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                DoneE  = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_op      <= '0;
            r_operand <= '0;
            r_prod    <= '0;
            r_rem     <= '0;
            r_result  <= '0;
        end else if (w_start) begin
            r_op    <= MulDivOpE;
            r_count <= '0;
            r_rem   <= '0;
            if (MulDivOpE[1]) begin
                r_operand <= SrcBE;
                r_prod    <= {{WIDTH{1'b0}}, SrcAE};
            end else begin
                r_operand <= SrcAE;
                r_prod    <= {{WIDTH{1'b0}}, SrcBE};
            end
            if (w_divZero) begin
                r_result <= MulDivOpE[0] ? SrcAE : '1;
            end
        end else if (w_step) begin
            r_count <= r_count + 1'b1;
            if (r_op[1]) begin
                r_rem               <= w_remNext;
                r_prod[WIDTH-1:0]   <= w_quoNext;
            end else begin
                r_prod <= w_mulNext;
            end
            if (w_last) begin
                r_result <= w_finalResult;
            end
        end
    end

    assign MulDivResultE = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: scoreboard of expected results, latency and
// stall-length checks, flush and reset aborts.
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst;
    logic        StartE;
    logic [1:0]  MulDivOpE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        FlushE;
    logic        StallMD;
    logic        DoneE;
    logic [31:0] MulDivResultE;
    logic        BusyMD;

    int          total = 0;
    int          bad = 0;
    logic [31:0] expQ[$];
    logic [31:0] lastResult = 32'h0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .StartE        (StartE),
        .MulDivOpE     (MulDivOpE),
        .SrcAE         (SrcAE),
        .SrcBE         (SrcBE),
        .FlushE        (FlushE),
        .StallMD       (StallMD),
        .DoneE         (DoneE),
        .MulDivResultE (MulDivResultE),
        .BusyMD        (BusyMD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        p = {32'h0, a} * {32'h0, b};
        case (op)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
        end
    endtask

    // Called in the first cycle the op is visible; operands are scrambled while it runs.
    task automatic waitDone(input string tag, input int expLatency);
        int          cycles;
        int          stalls;
        logic [31:0] exp;
        cycles = 0;
        stalls = 0;
        while (DoneE !== 1'b1 && cycles < 200) begin
            if (StallMD === 1'b1) stalls++;
            @(negedge clk);
            cycles++;
            SrcAE = $urandom;
            SrcBE = $urandom;
        end
        checkOutput({tag, " latency"}, 32'(cycles), 32'(expLatency));
        checkOutput({tag, " stall cycles"}, 32'(stalls), 32'(expLatency));
        checkOutput({tag, " stall in done"}, 32'(StallMD), 32'h0);
        exp = (expQ.size() > 0) ? expQ.pop_front() : 32'hDEAD_BEEF;
        checkOutput({tag, " result"}, MulDivResultE, exp);
        lastResult = exp;
        @(negedge clk);
        StartE = 1'b0;
        #1;
        checkOutput({tag, " idle busy"}, 32'(BusyMD), 32'h0);
        checkOutput({tag, " idle done"}, 32'(DoneE), 32'h0);
        checkOutput({tag, " result hold"}, MulDivResultE, lastResult);
    endtask

    task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
        @(negedge clk);
        StartE    = 1'b1;
        MulDivOpE = op;
        SrcAE     = a;
        SrcBE     = b;
        expQ.push_back(model(op, a, b));
        #1;
        waitDone(tag, (op[1] && b == 32'h0) ? 1 : 33);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        StartE    = 1'b0;
        FlushE    = 1'b0;
        MulDivOpE = 2'b00;
        SrcAE     = 32'h0;
        SrcBE     = 32'h0;
        repeat (3) @(negedge clk);
        checkOutput("reset done", 32'(DoneE), 32'h0);
        checkOutput("reset stall", 32'(StallMD), 32'h0);
        checkOutput("reset busy", 32'(BusyMD), 32'h0);
        checkOutput("reset result", MulDivResultE, 32'h0);
        rst = 1'b0;

        applyStimulus("mul small", 2'b00, 32'h0000_1234, 32'h0000_5678);
        applyStimulus("mulhu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus("mul max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus("divu 100/7", 2'b10, 32'd100, 32'd7);
        applyStimulus("remu 100/7", 2'b11, 32'd100, 32'd7);
        applyStimulus("divu msb/1", 2'b10, 32'h8000_0000, 32'd1);
        applyStimulus("remu msb/1", 2'b11, 32'h8000_0000, 32'd1);
        applyStimulus("divu by zero", 2'b10, 32'h1234_5678, 32'h0);
        applyStimulus("remu by zero", 2'b11, 32'h1234_5678, 32'h0);
        applyStimulus("divu random", 2'b10, 32'hDEAD_BEEF, 32'h0000_1235);
        applyStimulus("mulhu random", 2'b01, 32'hCAFE_F00D, 32'h1357_9BDF);

        // Start and flush in the same IDLE cycle must not begin an operation.
        @(negedge clk);
        StartE    = 1'b1;
        FlushE    = 1'b1;
        MulDivOpE = 2'b00;
        SrcAE     = 32'd3;
        SrcBE     = 32'd5;
        #1;
        checkOutput("start+flush stall", 32'(StallMD), 32'h0);
        @(negedge clk);
        StartE = 1'b0;
        FlushE = 1'b0;
        #1;
        checkOutput("start+flush busy", 32'(BusyMD), 32'h0);

        // Flush during RUN cycle 10.
        @(negedge clk);
        StartE    = 1'b1;
        MulDivOpE = 2'b00;
        SrcAE     = 32'd3;
        SrcBE     = 32'd5;
        #1;
        repeat (10) @(negedge clk);
        FlushE = 1'b1;
        #1;
        checkOutput("flush run busy", 32'(BusyMD), 32'h1);
        @(negedge clk);
        StartE = 1'b0;
        FlushE = 1'b0;
        #1;
        checkOutput("flush idle busy", 32'(BusyMD), 32'h0);
        checkOutput("flush no done", 32'(DoneE), 32'h0);
        checkOutput("flush result kept", MulDivResultE, lastResult);
        applyStimulus("divu after flush", 2'b10, 32'd100, 32'd7);

        // Reset during RUN, StartE held so the op restarts from scratch.
        @(negedge clk);
        StartE    = 1'b1;
        MulDivOpE = 2'b00;
        SrcAE     = 32'h0000_1234;
        SrcBE     = 32'h0000_5678;
        expQ.push_back(model(2'b00, 32'h0000_1234, 32'h0000_5678));
        #1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expQ.delete();
        #1;
        checkOutput("rst mid busy", 32'(BusyMD), 32'h0);
        checkOutput("rst mid done", 32'(DoneE), 32'h0);
        checkOutput("rst mid result", MulDivResultE, 32'h0);
        checkOutput("rst mid restart stall", 32'(StallMD), 32'h1);
        expQ.push_back(model(2'b00, 32'h0000_1234, 32'h0000_5678));
        waitDone("mul after reset", 33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
